// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
// Shared constants and types for the I2S master transmitter and its clock
// generator. Slot positions are counted from the ws edge, so the first data
// bit of each channel sits one slot after the word-select change.
//
// Contents:
//   I2S_WORD_LEN  - sck periods per channel slot (default geometry)
//   I2S_FRAME_LEN - sck periods per stereo frame
//   I2S_BC_W      - width of the exported bit_count
//   I2S_DATA_W    - default sample width per channel
//   I2S_L_START   - slot offset of the first data bit within a channel
//   I2S_R_START   - first right-channel data slot for the default geometry
//   i2s_pair_t    - left/right sample pair
// ----------------------------------------------------------------------------
package i2s_pkg;

   localparam int I2S_WORD_LEN  = 32;
   localparam int I2S_FRAME_LEN = 2 * I2S_WORD_LEN;
   localparam int I2S_BC_W      = 6;
   localparam int I2S_DATA_W    = 16;
   localparam int I2S_L_START   = 1;
   localparam int I2S_R_START   = I2S_WORD_LEN + I2S_L_START;

   typedef struct packed {
      logic [I2S_DATA_W-1:0] l;
      logic [I2S_DATA_W-1:0] r;
   } i2s_pair_t;

endpackage

// File: rtl/i2s_out_tx_if.sv
// ----------------------------------------------------------------------------
// i2s_out_tx_if
// Sample-pair handshake between a producer and the I2S transmitter.
//
// Signals:
//   in_l, in_r  - left/right sample (DATA_W bits each)
//   in_valid    - producer has a pair to offer
//   in_ready    - transmitter holding buffer is empty
// Modports:
//   master - the sample producer
//   slave  - the transmitter
// ----------------------------------------------------------------------------
interface i2s_out_tx_if
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W
);

   logic [DATA_W-1:0] in_l;
   logic [DATA_W-1:0] in_r;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_l, output in_r, output in_valid, input in_ready);
   modport slave  (input in_l, input in_r, input in_valid, output in_ready);

endinterface

// File: rtl/i2s_clk_gen.sv
// ----------------------------------------------------------------------------
// i2s_clk_gen
// I2S master frame timing: divides ck down to sck, tracks the slot position
// within the stereo frame and drives ws. Usable on its own to clock the I2S
// receiver as a master.
//
// Ports:
//   ck, rst_n     - system clock, async active-low reset
//   en            - run enable; when low every counter and output freezes
//   sck           - I2S bit clock, period 2*CLK_DIV ck cycles
//   ws            - word select, 0 = left slot half, 1 = right slot half
//   bit_count     - slot position 0..2*WORD_LEN-1, advances on sck falls
//   frame_start   - one-ck pulse in the cycle bit_count has wrapped to 0
//   fall_evt      - combinational: the coming ck edge is an sck fall
//   wrap_evt      - combinational: the coming sck fall wraps bit_count to 0
//   bit_count_nxt - combinational: slot position after the next sck fall
// ----------------------------------------------------------------------------
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int WORD_LEN = I2S_WORD_LEN
)(
   input  logic                ck,
   input  logic                rst_n,
   input  logic                en,
   output logic                sck,
   output logic                ws,
   output logic [I2S_BC_W-1:0] bit_count,
   output logic                frame_start,
   output logic                fall_evt,
   output logic                wrap_evt,
   output logic [I2S_BC_W-1:0] bit_count_nxt
);

   localparam int                  DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [I2S_BC_W-1:0] BC_LAST  = I2S_BC_W'(2 * WORD_LEN - 1);
   localparam logic [I2S_BC_W-1:0] WS_SLOT  = I2S_BC_W'(WORD_LEN);

   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic                sck_q, sck_d;
   logic                ws_q, ws_d;
   logic [I2S_BC_W-1:0] bit_count_q, bit_count_d;
   logic                frame_start_q, frame_start_d;

   // Divider and slot tracking. Everything that depends on the slot position
   // is updated only on the ck edge where sck goes 1->0, so data is stable
   // around every sck rise. With en low nothing moves and the pulse drops.
   always_comb begin
      div_cnt_d     = div_cnt_q;
      sck_d         = sck_q;
      ws_d          = ws_q;
      bit_count_d   = bit_count_q;
      frame_start_d = 1'b0;
      fall_evt      = 1'b0;
      wrap_evt      = 1'b0;
      bit_count_nxt = (bit_count_q == BC_LAST) ? '0 : bit_count_q + 1'b1;

      if (en) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            sck_d     = ~sck_q;
            if (sck_q) begin
               fall_evt      = 1'b1;
               wrap_evt      = (bit_count_nxt == '0);
               bit_count_d   = bit_count_nxt;
               ws_d          = (bit_count_nxt >= WS_SLOT);
               frame_start_d = wrap_evt;
            end
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   // Timing state register.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         sck_q         <= 1'b0;
         ws_q          <= 1'b0;
         bit_count_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         sck_q         <= sck_d;
         ws_q          <= ws_d;
         bit_count_q   <= bit_count_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign sck         = sck_q;
   assign ws          = ws_q;
   assign bit_count   = bit_count_q;
   assign frame_start = frame_start_q;

endmodule

// File: rtl/i2s_out_tx.sv
// ----------------------------------------------------------------------------
// i2s_out_tx
// I2S master transmitter. Sample pairs arrive through a valid/ready handshake
// into a one-entry holding buffer; at every frame wrap the buffer is moved
// into the frame shift register (or zeros are sent if it is empty) and the
// bits are shifted out MSB-first on sck falling edges.
//
// Ports:
//   ck, rst_n    - system clock, async active-low reset
//   en           - run enable (handshake keeps working while low)
//   in_if        - sample-pair handshake (slave side: in_l, in_r, in_valid,
//                  in_ready)
//   sck, ws, sd  - I2S bus
//   bit_count    - slot position 0..2*WORD_LEN-1, shared with the receiver
//   frame_start  - one-ck pulse when bit_count wraps to 0
//   underrun     - one-ck pulse on a frame load with an empty buffer
//                  (only with I2S_OUT_UNDERRUN_EN defined)
//   underrun_cnt - saturating count of underrun pulses
//                  (only with I2S_OUT_UNDERRUN_EN defined)
//
// Parameters: CLK_DIV >= 2, DATA_W + 1 <= WORD_LEN, 2*WORD_LEN <= 64.
// Optional feature macro: I2S_OUT_UNDERRUN_EN.
// ----------------------------------------------------------------------------
module i2s_out_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int DATA_W   = I2S_DATA_W,
   parameter int WORD_LEN = I2S_WORD_LEN
)(
   input  logic                ck,
   input  logic                rst_n,
   input  logic                en,
   i2s_out_tx_if.slave         in_if,
   output logic                sck,
   output logic                ws,
   output logic                sd,
   output logic [I2S_BC_W-1:0] bit_count,
   output logic                frame_start
`ifdef I2S_OUT_UNDERRUN_EN
   ,
   output logic                underrun,
   output logic [7:0]          underrun_cnt
`endif
);

   localparam int                  FRAME_W = 2 * DATA_W;
   localparam logic [I2S_BC_W-1:0] L_FIRST = I2S_BC_W'(I2S_L_START);
   localparam logic [I2S_BC_W-1:0] L_LAST  = I2S_BC_W'(DATA_W);
   localparam logic [I2S_BC_W-1:0] R_FIRST = I2S_BC_W'(WORD_LEN + I2S_L_START);
   localparam logic [I2S_BC_W-1:0] R_LAST  = I2S_BC_W'(WORD_LEN + DATA_W);

   logic                fall_evt;
   logic                wrap_evt;
   logic [I2S_BC_W-1:0] bit_count_nxt;

   logic [DATA_W-1:0]   buf_l_q, buf_l_d;
   logic [DATA_W-1:0]   buf_r_q, buf_r_d;
   logic                buf_full_q, buf_full_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic                sd_q, sd_d;

   logic                accept;
   logic                load;
   logic                data_slot;

   i2s_clk_gen #(
      .CLK_DIV  (CLK_DIV),
      .WORD_LEN (WORD_LEN)
   ) u_clk_gen (
      .ck            (ck),
      .rst_n         (rst_n),
      .en            (en),
      .sck           (sck),
      .ws            (ws),
      .bit_count     (bit_count),
      .frame_start   (frame_start),
      .fall_evt      (fall_evt),
      .wrap_evt      (wrap_evt),
      .bit_count_nxt (bit_count_nxt)
   );

   // Accept only into an empty buffer, and consume only a full one, so the
   // two can never land on the same edge.
   assign accept         = in_if.in_valid && !buf_full_q;
   assign load           = wrap_evt && buf_full_q;
   assign in_if.in_ready = !buf_full_q;

   // The left and right payloads are shifted out of one register, so the
   // MSB of the frame is always the next data bit regardless of channel.
   assign data_slot = ((bit_count_nxt >= L_FIRST) && (bit_count_nxt <= L_LAST)) ||
                      ((bit_count_nxt >= R_FIRST) && (bit_count_nxt <= R_LAST));

   // Holding buffer, frame load and serializer.
   always_comb begin
      buf_l_d    = buf_l_q;
      buf_r_d    = buf_r_q;
      buf_full_d = buf_full_q;
      frame_d    = frame_q;
      sd_d       = sd_q;

      if (accept) begin
         buf_l_d    = in_if.in_l;
         buf_r_d    = in_if.in_r;
         buf_full_d = 1'b1;
      end

      if (load) begin
         buf_full_d = 1'b0;
      end

      if (wrap_evt) begin
         frame_d = buf_full_q ? {buf_l_q, buf_r_q} : '0;
         sd_d    = 1'b0;
      end else if (fall_evt) begin
         if (data_slot) begin
            sd_d    = frame_q[FRAME_W-1];
            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
         end else begin
            sd_d    = 1'b0;
         end
      end
   end

   // Datapath state register.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         buf_l_q    <= '0;
         buf_r_q    <= '0;
         buf_full_q <= 1'b0;
         frame_q    <= '0;
         sd_q       <= 1'b0;
      end else begin
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         buf_full_q <= buf_full_d;
         frame_q    <= frame_d;
         sd_q       <= sd_d;
      end
   end

   assign sd = sd_q;

`ifdef I2S_OUT_UNDERRUN_EN
   logic       underrun_q, underrun_d;
   logic [7:0] underrun_cnt_q, underrun_cnt_d;

   // An underrun is a frame wrap that finds the buffer empty; the count
   // includes the pulse from the same edge and sticks at 255.
   always_comb begin
      underrun_d     = wrap_evt && !buf_full_q;
      underrun_cnt_d = underrun_cnt_q;
      if (underrun_d && (underrun_cnt_q != 8'hFF)) begin
         underrun_cnt_d = underrun_cnt_q + 8'd1;
      end
   end

   // Underrun state register.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: doc/i2s_out_tx.md
Name: i2s_out_tx

Overview:
- I2S master transmitter; companion to the existing I2S receiver.
- Generates sck, ws and the 6-bit frame bit_count from the system clock, and serializes 16-bit left/right samples onto sd.
- bit_count and sck are exported so the receiver can be driven from the same frame timing.
- Samples arrive through a valid/ready handshake into a one-entry holding buffer.

Parameters:
- CLK_DIV, 4: ck cycles per sck half-period (>=2).
- DATA_W, 16: sample width per channel.
- WORD_LEN, 32: sck periods per channel slot (DATA_W+1 <= WORD_LEN).

Ports:
- ck  in  1  system clock
- rst_n  in  1  async active-low reset
- en  in  1  run enable
- in_l  in  DATA_W  left sample
- in_r  in  DATA_W  right sample
- in_valid  in  1  sample pair valid
- in_ready  out  1  holding buffer empty
- sck  out  1  I2S bit clock
- ws  out  1  word select, 0=left 1=right
- sd  out  1  serial data
- bit_count  out  6  slot position 0..2*WORD_LEN-1
- frame_start  out  1  one-ck pulse when bit_count wraps to 0

Behaviour:
- Reset (async, rst_n=0):
  - sck=0, ws=0, sd=0, bit_count=0, frame_start=0.
  - Divider, shift register and holding buffer are all cleared; buf_full=0.
  - in_ready=!buf_full, so in_ready=1 during and after reset.
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1; at CLK_DIV-1 it wraps and sck toggles. sck period = 2*CLK_DIV ck cycles.
- Fall event (the ck edge on which sck toggles 1->0), all registered on that edge:
  - bit_count <= (bit_count+1) mod 2*WORD_LEN.
  - ws <= (new bit_count >= WORD_LEN).
  - sd <= the bit for the new slot.
  - Data therefore changes on sck falling edges and is stable on rising edges.
- Slot map:
  - Slot 0 and slot WORD_LEN carry 0 (the I2S one-bit delay after the ws change).
  - Slots 1..DATA_W carry left data MSB-first; slots WORD_LEN+1..WORD_LEN+DATA_W carry right data MSB-first.
  - All remaining slots carry 0.
- Frame load: on the fall event where bit_count becomes 0:
  - frame_start pulses for that one ck cycle.
  - If buf_full=1: the frame register loads {buf_l, buf_r} and buf_full clears on the same edge.
  - If buf_full=0 (underrun): the frame register loads zeros and the frame transmits silence.
- Handshake:
  - A transfer occurs on any ck edge with in_valid && in_ready; it captures in_l/in_r and sets buf_full.
  - Accept and load can never coincide, because accept requires buf_full=0 and load only consumes when buf_full=1.
  - in_ready returns high on the ck after a load.
- First frame after reset: bit_count starts at 0 with no fall event, so frame 0 is silence. The first sample pair is sent in the frame beginning at the next wrap.
- en=0:
  - div_cnt, sck, bit_count, ws and sd freeze at their current values; frame_start=0.
  - The handshake still operates.
  - Resuming continues from the frozen position; no glitch is produced.
- Reset mid-frame aborts immediately: all outputs return to reset values and the buffered sample is discarded.

Optional Feature:
- Macro I2S_OUT_UNDERRUN_EN defined:
  - Adds output underrun (1 bit), a one-ck pulse on a frame load with buf_full=0.
  - Adds output underrun_cnt (8 bits), which increments on each underrun pulse, saturates at 255 and resets to 0.
- Macro undefined: neither port nor its logic exists; the rest of the behaviour is identical.

Decomposition:
- Package i2s_pkg:
  - Constants I2S_WORD_LEN=32 and I2S_FRAME_LEN=64.
  - Constant I2S_BC_W=6 (bit_count width).
  - Left/right slot-start constants.
  - A sample-pair typedef {l,r}.
- Sub-module i2s_clk_gen: divider, sck, ws, bit_count, a fall-event strobe and frame_start. It is reusable to drive the I2S receiver as a master. The datapath (buffer, frame shift, handshake) stays in i2s_out_tx.

Test Plan:
- Bench parameters CLK_DIV=2, DATA_W=16, WORD_LEN=32.
- Reset release, en=1, no samples -> sck period 4 ck; ws=0 for 32 sck periods then 1 for 32; sd constant 0; bit_count sequences 0..63 and wraps; frame_start pulses once per 256 ck.
- Push L=0xA5C3, R=0x0001 before the frame-1 wrap -> frame 1:
  - slot 0 = 0; slots 1..16 = 1010010111000011; slots 17..31 = 0.
  - slot 32 = 0; slots 33..48 = 0x0001 MSB-first (only slot 48 = 1).
  - in_ready returns to 1 one ck after frame_start.
- Hold in_valid high with a new pair every frame (0x8000/0x7FFF, then 0xFFFF/0x0000) -> each pair is sent exactly once, in order; in_ready is low from accept until the next frame_start.
- Offer a second pair while buf_full=1 -> not accepted (in_ready=0); it is accepted on the ck after the load, and the sample already loaded is unaffected.
- Deassert en for 10 ck mid-slot 20 -> sck, ws, sd, bit_count hold; on resume the sequence continues exactly where it stopped. Then assert rst_n=0 mid-frame -> all outputs go to 0 immediately and in_ready=1.
- With I2S_OUT_UNDERRUN_EN defined: 3 empty frames -> 3 underrun pulses, underrun_cnt=3. Forcing 300 underruns -> underrun_cnt stays at 255.
